// File: rtl/xfipcs_rx_gearbox_pkg.sv
// Shared XFIPCS constants and types for the 32->66 receive gearbox.
package xfipcs_rx_gearbox_pkg;

  localparam int GB_IN_W  = 32;  // SerDes word width
  localparam int BLK_W    = 66;  // 64b/66b block width
  localparam int GB_BUF_W = 98;  // worst case: 65 leftover bits + one word
  localparam int GB_CNT_W = 7;   // occupancy count 0..97

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  // Header sits in the low bits so the struct maps 1:1 onto buffer [65:0].
  typedef struct packed {
    logic [BLK_W-3:0] payload;
    logic [1:0]       header;
  } gb_blk_t;

endpackage

// File: rtl/xfipcs_rx_gearbox_if.sv
// Word-in / block-out bus of the receive gearbox.
interface xfipcs_rx_gearbox_if;
  import xfipcs_rx_gearbox_pkg::*;

  logic               rx_valid;
  logic [GB_IN_W-1:0] rx_data;
  logic               blk_valid;
  logic [1:0]         blk_header;
  logic [BLK_W-3:0]   blk_payload;

  // master: word source / block sink; slave: the gearbox
  modport master (output rx_valid, rx_data, input blk_valid, blk_header, blk_payload);
  modport slave  (input rx_valid, rx_data, output blk_valid, blk_header, blk_payload);

endinterface

// File: rtl/xfipcs_gb_slip_ctrl.sv
// Slip request edge detect, pending flag and slip-done delay pipe.
module xfipcs_gb_slip_ctrl #(
  parameter int SLIP_DONE_DLY = 1  // 1..4
) (
  input  logic clk,
  input  logic reset,
  input  logic slip,
  input  logic has_data,       // at least one bit available this cycle
  output logic apply,          // drop one bit this cycle
  output logic slip_done_set
);

  logic                     slip_q;
  logic                     armed;    // slip has been seen low since reset
  logic                     pending;
  logic                     rise;
  logic [SLIP_DONE_DLY-1:0] vld_pipe;

  // A slip held through reset must go low before it can request again.
  assign rise          = slip & ~slip_q & armed;
  assign apply         = pending & has_data;
  assign slip_done_set = vld_pipe[SLIP_DONE_DLY-1];

  // Edge detect, pending request (edges while pending are absorbed), done pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      slip_q   <= 1'b0;
      armed    <= ~slip;
      pending  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      slip_q      <= slip;
      armed       <= armed | ~slip;
      pending     <= apply ? 1'b0 : (pending | rise);
      vld_pipe[0] <= apply;
      for (int i = 1; i < SLIP_DONE_DLY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

endmodule

// File: rtl/xfipcs_rx_gearbox.sv
// 32-bit SerDes words to 66-bit blocks, with one-bit slip for block lock.
module xfipcs_rx_gearbox
  import xfipcs_rx_gearbox_pkg::*;
#(
  parameter int SLIP_DONE_DLY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  xfipcs_rx_gearbox_if.slave      gb,
  input  logic                    slip,
  output logic                    sh_valid,
  output logic                    test_sh_set,
  output logic                    slip_done_set
);

  localparam logic [GB_CNT_W-1:0] BLK_N = GB_CNT_W'(BLK_W);
  localparam logic [GB_CNT_W-1:0] WRD_N = GB_CNT_W'(GB_IN_W);

  logic [GB_BUF_W-1:0] sbuf_q;   // bit 0 is the oldest received bit
  logic [GB_CNT_W-1:0] n_q;
  logic [GB_BUF_W-1:0] merged;
  logic [GB_BUF_W-1:0] shifted;
  logic [GB_CNT_W-1:0] n1;
  logic                apply;
  logic                has_data;
  gb_blk_t             blk_q;
  logic                blk_vld_q;

  // The incoming word counts as data, so a slip deferred at n=0 lands on
  // the first bit of the next word.
  assign has_data = (n_q != '0) | gb.rx_valid;

  xfipcs_gb_slip_ctrl #(.SLIP_DONE_DLY(SLIP_DONE_DLY)) u_slip (
    .clk           (clk),
    .reset         (reset),
    .slip          (slip),
    .has_data      (has_data),
    .apply         (apply),
    .slip_done_set (slip_done_set)
  );

  // Append at n then drop bit 0 on slip; equal to slipping first and
  // appending at n-s, and also covers the empty-buffer slip case.
  always_comb begin
    merged = sbuf_q;
    if (gb.rx_valid)
      merged = sbuf_q | ({{(GB_BUF_W-GB_IN_W){1'b0}}, gb.rx_data} << n_q);
    shifted = apply ? (merged >> 1) : merged;
    n1      = n_q + (gb.rx_valid ? WRD_N : '0) - {{(GB_CNT_W-1){1'b0}}, apply};
  end

  // Buffer/count update and block extraction; bits above n stay zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf_q    <= '0;
      n_q       <= '0;
      blk_q     <= '0;
      blk_vld_q <= 1'b0;
    end else if (n1 >= BLK_N) begin
      blk_q     <= shifted[BLK_W-1:0];
      sbuf_q    <= shifted >> BLK_W;
      n_q       <= n1 - BLK_N;
      blk_vld_q <= 1'b1;
    end else begin
      sbuf_q    <= shifted;
      n_q       <= n1;
      blk_vld_q <= 1'b0;
    end
  end

  assign gb.blk_valid   = blk_vld_q;
  assign gb.blk_header  = blk_q.header;
  assign gb.blk_payload = blk_q.payload;
  assign sh_valid       = blk_q.header[0] ^ blk_q.header[1];
  assign test_sh_set    = blk_vld_q;

endmodule

// File: doc/xfipcs_rx_gearbox.md
XFIPCS_RX_GEARBOX -- requirements
Module: xfipcs_rx_gearbox

Interface
REQ-001 Parameter SLIP_DONE_DLY, default 1: cycles from slip application to the slip_done_set pulse; legal range 1..4.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous reset, active-high.
REQ-004 rx_valid  in  1  rx_data carries a new word this cycle.
REQ-005 rx_data  in  32  received SerDes word; bit 0 is the earliest received.
REQ-006 slip  in  1  slip request from the lock FSM; held high until slip_done_set is seen.
REQ-007 blk_valid  out  1  one-cycle pulse: blk_header and blk_payload hold a new 66-bit block.
REQ-008 blk_header  out  2  sync header, buffer bits [1:0].
REQ-009 blk_payload  out  64  block payload, buffer bits [65:2].
REQ-010 sh_valid  out  1  blk_header[0] XOR blk_header[1]; meaningful only while blk_valid=1.
REQ-011 test_sh_set  out  1  equal to blk_valid; drives the lock FSM test_sh_set input.
REQ-012 slip_done_set  out  1  one-cycle pulse: the requested slip has been applied.

Function
REQ-013 Hold a 98-bit shift buffer plus a 7-bit occupancy count n (0..97); the bit at buffer index 0 is the oldest.
REQ-014 Compute each cycle: s = 1 if a slip is applied this cycle, else 0; a = 32 if rx_valid=1, else 0; n1 = n - s + a.
REQ-015 Slip application discards buffer bit 0 and shifts the buffer down by one, before any append.
REQ-016 Append places rx_data at buffer indices [n-s+31 : n-s].
REQ-017 If n1 >= 66: register bits [65:0] to the block outputs, pulse blk_valid next cycle, shift the buffer down 66, and set n = n1-66; otherwise set n = n1.
REQ-018 Latency: blk_valid asserts exactly one cycle after the clock edge that accepted the completing word.
REQ-019 n never exceeds 97.
REQ-020 At most one block is emitted per cycle.
REQ-021 Slip request detection: a rising edge of slip (slip=1, registered slip=0) sets slip_pending; a held-high slip does not retrigger.
REQ-022 Slip application: when slip_pending=1 and n >= 1, apply the slip and clear slip_pending.
REQ-023 Slip deferral: when slip_pending=1 and n=0, defer the slip to the first cycle with n >= 1.
REQ-024 slip_done_set pulses for one cycle exactly SLIP_DONE_DLY cycles after the applying cycle.
REQ-025 A new rising edge of slip while slip_pending=1 is absorbed: exactly one bit is dropped.
REQ-026 Slip and rx_valid in the same cycle: both take effect per REQ-014, and block extraction uses n1.
REQ-027 rx_valid=0 with no slip: buffer, n, and outputs hold, except that blk_valid deasserts.
REQ-028 blk_header and blk_payload hold their last values between blk_valid pulses.

Reset
REQ-029 With reset=1 at a clock edge: n, slip_pending, the registered slip, and the slip-done delay pipe go to 0; blk_valid, test_sh_set, and slip_done_set go to 0.
REQ-030 With reset=1 at a clock edge: blk_header, blk_payload, and the buffer go to 0, and sh_valid reads 0.
REQ-031 Reset asserted mid-block discards partial data; the first post-reset block starts at the first rx_data bit 0 accepted after reset deasserts.
REQ-032 Reset takes priority over rx_valid and slip in the same cycle.
REQ-033 A slip held high across reset deassertion triggers only on a fresh rising edge.

Structure
REQ-034 Constants go in the shared XFIPCS package: GB_IN_W=32, BLK_W=66, GB_BUF_W=98, SH_DATA=2'b10, SH_CTRL=2'b01.
REQ-035 One sub-module, xfipcs_gb_slip_ctrl, contains the slip edge detection, pending flag, and SLIP_DONE_DLY pipe.
REQ-036 The datapath stays in the top level.
REQ-037 Output ports connect directly to the lock FSM inputs: sh_valid, test_sh_set, and slip_done_set; slip comes from the lock FSM.

Verification
REQ-038 Scenario aligned stream: reset, then continuous 32-bit words carrying back-to-back blocks with header 01 at offset 0 -> first blk_valid one cycle after word 3, with header 01 and sh_valid=1.
REQ-039 Scenario block count: 33 continuous words -> exactly 16 blocks, and n ends at 0.
REQ-040 Scenario header slip: stream offset by 1 bit -> headers invalid; one slip pulse -> one slip_done_set pulse SLIP_DONE_DLY cycles after application, and all later headers valid.
REQ-041 Scenario slip hold: slip held high 20 cycles -> exactly one bit dropped and one slip_done_set pulse.
REQ-042 Scenario slip at empty: slip asserted at n=0 with rx_valid=0 for 3 cycles, then one word -> slip applied on the word cycle, and n=31 afterwards.
REQ-043 Scenario mid-block reset: reset asserted with n=50 -> no blk_valid during or after reset until 3 fresh words, and the first block starts at the first post-reset bit 0.
